clk_div_sched: RTL and testbench

//  Controller for the three-stage clock-division chain (in_clk -> f0 -> f1 -> f2).

---
 rtl/clk_div_sched_pkg.sv | 20 ++
 rtl/clk_div_sched_div_stage.sv | 39 +++
 rtl/clk_div_sched.sv | 136 +++++++++++++
 tb/tb_clk_div_sched.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_sched_pkg.sv
// Shared types and defaults for the three-stage clock-enable divider chain.
package clk_div_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PEND,
        ST_LOAD
    } state_t;

    localparam int unsigned DEF_DIV0_C = 50000;
    localparam int unsigned DEF_DIV1_C = 2;
    localparam int unsigned DEF_DIV2_C = 2;

    // A ratio of zero behaves as one: a tick on every enabling event.
    function automatic logic [31:0] ratio_clamp(input logic [31:0] n);
        return (n == '0) ? 32'd1 : n;
    endfunction

endpackage

// File: rtl/clk_div_sched_div_stage.sv
// One divide stage: counts enables 0..ratio-1, strobes and toggles its level on the wrap.
module div_stage #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_ratio,
    output logic         o_evt,
    output logic         o_tick,
    output logic         o_lvl
);

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    // Ratio is always >= 1 here, so ratio-1 cannot underflow.
    assign w_wrap = (r_cnt >= (i_ratio - W'(1)));
    assign o_evt  = i_en & w_wrap;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            o_tick <= 1'b0;
            o_lvl  <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            o_tick <= 1'b0;
        end else begin
            o_tick <= o_evt;
            o_lvl  <= o_lvl ^ o_evt;
            if (i_en) begin
                r_cnt <= w_wrap ? '0 : r_cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Clock-division chain controller: FSM, shadow ratios and config handshake around three div_stages.
module clk_div_sched
    import clk_div_sched_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned SUB_W    = 8,
    parameter int unsigned DEF_DIV0 = DEF_DIV0_C,
    parameter int unsigned DEF_DIV1 = DEF_DIV1_C,
    parameter int unsigned DEF_DIV2 = DEF_DIV2_C
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div0,
    input  logic [SUB_W-1:0] cfg_div1,
    input  logic [SUB_W-1:0] cfg_div2,
    output logic             busy,
    output logic             f0_tick,
    output logic             f1_tick,
    output logic             f2_tick,
    output logic             f0_lvl,
    output logic             f1_lvl,
    output logic             f2_lvl
);

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_sh_div0, r_div0;
    logic [SUB_W-1:0] r_sh_div1, r_div1;
    logic [SUB_W-1:0] r_sh_div2, r_div2;

    logic w_accept;
    logic w_load;
    logic w_en0;
    logic w_f0_evt, w_f1_evt, w_f2_evt;

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        busy        = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid)  w_state_nxt = ST_LOAD;
                else if (run)   w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                cfg_ready = 1'b1;
                if (cfg_valid)  w_state_nxt = ST_PEND;
                else if (!run)  w_state_nxt = ST_IDLE;
            end
            ST_PEND: begin
                busy = 1'b1;
                if (!run || w_f2_evt) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                busy        = 1'b1;
                w_load      = 1'b1;
                w_state_nxt = run ? ST_RUN : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = cfg_valid & cfg_ready;
    // Counting follows run directly so a pause freezes on the very edge run drops.
    assign w_en0    = run & ~w_load;

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            r_sh_div0 <= '0;
            r_sh_div1 <= '0;
            r_sh_div2 <= '0;
            r_div0    <= CNT_W'(ratio_clamp(32'(DEF_DIV0)));
            r_div1    <= SUB_W'(ratio_clamp(32'(DEF_DIV1)));
            r_div2    <= SUB_W'(ratio_clamp(32'(DEF_DIV2)));
        end else begin
            if (w_accept) begin
                r_sh_div0 <= cfg_div0;
                r_sh_div1 <= cfg_div1;
                r_sh_div2 <= cfg_div2;
            end
            if (w_load) begin
                r_div0 <= CNT_W'(ratio_clamp(32'(r_sh_div0)));
                r_div1 <= SUB_W'(ratio_clamp(32'(r_sh_div1)));
                r_div2 <= SUB_W'(ratio_clamp(32'(r_sh_div2)));
            end
        end
    end

    div_stage #(.W(CNT_W)) u_stage0 (
        .i_clk   (in_clk),
        .i_rst_n (in_rst_n),
        .i_en    (w_en0),
        .i_clr   (w_load),
        .i_ratio (r_div0),
        .o_evt   (w_f0_evt),
        .o_tick  (f0_tick),
        .o_lvl   (f0_lvl)
    );

    div_stage #(.W(SUB_W)) u_stage1 (
        .i_clk   (in_clk),
        .i_rst_n (in_rst_n),
        .i_en    (w_f0_evt),
        .i_clr   (w_load),
        .i_ratio (r_div1),
        .o_evt   (w_f1_evt),
        .o_tick  (f1_tick),
        .o_lvl   (f1_lvl)
    );

    div_stage #(.W(SUB_W)) u_stage2 (
        .i_clk   (in_clk),
        .i_rst_n (in_rst_n),
        .i_en    (w_f1_evt),
        .i_clr   (w_load),
        .i_ratio (r_div2),
        .o_evt   (w_f2_evt),
        .o_tick  (f2_tick),
        .o_lvl   (f2_lvl)
    );

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched with small default ratios (4/2/2).
module tb_clk_div_sched;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SUB_W = 8;

    logic             in_clk    = 1'b0;
    logic             in_rst_n  = 1'b0;
    logic             run       = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_div0  = '0;
    logic [SUB_W-1:0] cfg_div1  = '0;
    logic [SUB_W-1:0] cfg_div2  = '0;
    logic             cfg_ready, busy;
    logic             f0_tick, f1_tick, f2_tick;
    logic             f0_lvl, f1_lvl, f2_lvl;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;
    logic        l0, l1, l2;

    clk_div_sched #(
        .CNT_W    (CNT_W),
        .SUB_W    (SUB_W),
        .DEF_DIV0 (4),
        .DEF_DIV1 (2),
        .DEF_DIV2 (2)
    ) dut (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div0  (cfg_div0),
        .cfg_div1  (cfg_div1),
        .cfg_div2  (cfg_div2),
        .busy      (busy),
        .f0_tick   (f0_tick),
        .f1_tick   (f1_tick),
        .f2_tick   (f2_tick),
        .f0_lvl    (f0_lvl),
        .f1_lvl    (f1_lvl),
        .f2_lvl    (f2_lvl)
    );

    always #5 in_clk = ~in_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // cyc counts edges since run was raised; outputs are sampled 1ns after each edge.
    task automatic step();
        @(posedge in_clk);
        #1;
        cyc++;
    endtask

    task automatic check_ticks(input logic t0, input logic t1, input logic t2);
        l0 = l0 ^ t0;
        l1 = l1 ^ t1;
        l2 = l2 ^ t2;
        check_eq("f0_tick", f0_tick, t0);
        check_eq("f1_tick", f1_tick, t1);
        check_eq("f2_tick", f2_tick, t2);
        check_eq("f0_lvl", f0_lvl, l0);
        check_eq("f1_lvl", f1_lvl, l1);
        check_eq("f2_lvl", f2_lvl, l2);
    endtask

    task automatic do_reset();
        in_rst_n  = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        repeat (3) step();
        l0 = 1'b0;
        l1 = 1'b0;
        l2 = 1'b0;
        check_ticks(1'b0, 1'b0, 1'b0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", cfg_ready, 1);
        in_rst_n = 1'b1;
        cyc      = 0;
    endtask

    initial begin
        logic t0, t1, t2;

        // Defaults, then a mid-run ratio change applied on the f2 boundary at cycle 16.
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 42; k++) begin
            step();
            t0 = (cyc <= 16) ? (cyc % 4 == 0) : (cyc > 17 && (cyc - 17) % 3 == 0);
            t1 = (cyc <= 16) ? (cyc % 8 == 0) : (cyc > 17 && (cyc - 17) % 6 == 0);
            t2 = (cyc == 16) || (cyc > 17 && (cyc - 17) % 12 == 0);
            check_ticks(t0, t1, t2);
            check_eq("cfg_busy", busy, (cyc >= 5 && cyc <= 16));
            check_eq("cfg_ready", cfg_ready, !(cyc >= 5 && cyc <= 16));
            if (cyc == 4) begin
                cfg_valid = 1'b1;
                cfg_div0  = 16'd3;
                cfg_div1  = 8'd2;
                cfg_div2  = 8'd2;
            end
            if (cyc == 5) cfg_valid = 1'b0;
        end

        // Pause for 5 edges with c0 frozen at 2; the period resumes where it stopped.
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 38; k++) begin
            step();
            t0 = (cyc <= 10) ? (cyc % 4 == 0) : (cyc >= 17 && (cyc - 17) % 4 == 0);
            t1 = (cyc == 8) || (cyc >= 21 && (cyc - 21) % 8 == 0);
            t2 = (cyc == 21) || (cyc == 37);
            check_ticks(t0, t1, t2);
            check_eq("pause_busy", busy, 0);
            if (cyc == 10) run = 1'b0;
            if (cyc == 15) run = 1'b1;
        end

        // Zero/one ratios loaded from IDLE: every stage ticks on every cycle.
        do_reset();
        cfg_valid = 1'b1;
        cfg_div0  = 16'd0;
        cfg_div1  = 8'd1;
        cfg_div2  = 8'd1;
        step();
        check_eq("idle_load_busy", busy, 1);
        check_eq("idle_load_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        step();
        check_eq("idle_done_busy", busy, 0);
        check_ticks(1'b0, 1'b0, 1'b0);
        cyc = 0;
        run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check_ticks(1'b1, 1'b1, 1'b1);
        end
        run = 1'b0;
        step();
        check_ticks(1'b0, 1'b0, 1'b0);

        // Reset while a ratio of 7 is pending: defaults return and 7 never takes effect.
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check_ticks(cyc % 4 == 0, cyc % 8 == 0, 1'b0);
            check_eq("pend_busy", busy, (cyc >= 5));
            if (cyc == 4) begin
                cfg_valid = 1'b1;
                cfg_div0  = 16'd7;
                cfg_div1  = 8'd2;
                cfg_div2  = 8'd2;
            end
            if (cyc == 5) cfg_valid = 1'b0;
        end
        in_rst_n = 1'b0;
        run      = 1'b0;
        repeat (2) step();
        check_eq("pend_rst_busy", busy, 0);
        check_eq("pend_rst_ready", cfg_ready, 1);
        in_rst_n = 1'b1;
        l0 = 1'b0;
        l1 = 1'b0;
        l2 = 1'b0;
        cyc = 0;
        run = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            check_ticks(cyc % 4 == 0, cyc % 8 == 0, 1'b0);
            check_eq("post_rst_busy", busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
